// File: rtl/cpu_pkg.sv
// Shared encodings for the mini-CPU instruction-cycle controller.
// State, one-hot phase constants and the default START hold time.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_RUN   = 2'd1,
      ST_SLEEP = 2'd2
   } state_t;

   localparam logic [3:0] PH_NONE = 4'b0000;
   localparam logic [3:0] PH_Q1   = 4'b0001;
   localparam logic [3:0] PH_Q2   = 4'b0010;
   localparam logic [3:0] PH_Q3   = 4'b0100;
   localparam logic [3:0] PH_Q4   = 4'b1000;

   localparam int STARTUP_CYCLES_DEF = 4;

endpackage

// File: rtl/sync_2ff.sv
// Multi-stage flop synchronizer for a single asynchronous level.
// Output follows the input after STAGES clocks; cleared by reset.
module sync_2ff #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_sync <= '0;
      else
         r_sync <= {r_sync[STAGES-2:0], i_async};
   end

   assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/instr_sequencer.sv
// Q1-Q4 instruction-cycle controller: phase/state FSM, datapath strobes,
// fetch flush on branches and taken skips, SLEEP/wake and TO/PD bits.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int STARTUP_CYCLES = STARTUP_CYCLES_DEF,
   parameter int WAKE_SYNC      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stall,
   input  logic       wake_req,
   input  logic       GOTO,
   input  logic       CALL,
   input  logic       RETLW,
   input  logic       SLEEP,
   input  logic       CLRWDT,
   input  logic       FSZ,
   input  logic       BTFSS,
   input  logic       f_rd,
   input  logic       f_wr,
   input  logic       W_wr,
   input  logic       STT_en,
   input  logic       alu_zero,
   output logic [3:0] phase,
   output logic       f_rd_stb,
   output logic       f_we,
   output logic       w_we,
   output logic       stt_we,
   output logic       ir_load,
   output logic       pc_inc,
   output logic       pc_load,
   output logic       stack_push,
   output logic       stack_pop,
   output logic       wdt_clr,
   output logic       nop_cycle,
   output logic       sleeping,
   output logic       to_n,
   output logic       pd_n
);

   localparam logic [7:0] START_LAST = 8'(STARTUP_CYCLES - 1);

   logic       w_wake;
   state_t     r_state, w_state_nxt;
   logic [3:0] r_phase, w_phase_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;
   logic       r_nop, w_nop_nxt;
   logic       r_to_n, w_to_n_nxt;
   logic       r_pd_n, w_pd_n_nxt;
   logic       w_act, w_q2, w_q4, w_exec, w_branch, w_take, w_sleep_exec;

   // Runs regardless of stall so a wake is never delayed.
   sync_2ff #(.STAGES(WAKE_SYNC)) u_wake_sync (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_async (wake_req),
      .o_sync  (w_wake)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_START;
         r_phase <= PH_NONE;
         r_cnt   <= 8'd0;
         r_nop   <= 1'b1;
         r_to_n  <= 1'b1;
         r_pd_n  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_cnt   <= w_cnt_nxt;
         r_nop   <= w_nop_nxt;
         r_to_n  <= w_to_n_nxt;
         r_pd_n  <= w_pd_n_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_cnt_nxt   = r_cnt;
      w_nop_nxt   = r_nop;
      w_to_n_nxt  = r_to_n;
      w_pd_n_nxt  = r_pd_n;

      w_act    = (r_state == ST_RUN) && !stall;
      w_q2     = w_act && (r_phase == PH_Q2);
      w_q4     = w_act && (r_phase == PH_Q4);
      w_exec   = !r_nop;
      w_branch = GOTO | CALL | RETLW;
      // A flushed cycle never takes, so skips cannot chain.
      w_take   = w_exec && (w_branch | (FSZ & alu_zero) | (BTFSS & ~alu_zero));
      w_sleep_exec = w_exec && SLEEP && !w_take;

      case (r_state)
         ST_START: begin
            if (r_cnt == START_LAST) begin
               w_state_nxt = ST_RUN;
               w_phase_nxt = PH_Q1;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         ST_RUN: begin
            if (!stall) begin
               w_phase_nxt = {r_phase[2:0], r_phase[3]};
               if (r_phase == PH_Q4) begin
                  w_nop_nxt = w_take;
                  if (w_sleep_exec) begin
                     w_state_nxt = ST_SLEEP;
                     w_phase_nxt = PH_NONE;
                     w_pd_n_nxt  = 1'b0;
                     w_to_n_nxt  = 1'b1;
                  end else if (w_exec && CLRWDT) begin
                     w_pd_n_nxt = 1'b1;
                     w_to_n_nxt = 1'b1;
                  end
               end
            end
         end
         ST_SLEEP: begin
            // The instruction fetched alongside SLEEP runs on wake.
            if (w_wake) begin
               w_state_nxt = ST_RUN;
               w_phase_nxt = PH_Q1;
               w_nop_nxt   = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_START;
            w_phase_nxt = PH_NONE;
            w_cnt_nxt   = 8'd0;
         end
      endcase

      f_rd_stb   = w_q2 && w_exec && f_rd;
      f_we       = w_q4 && w_exec && f_wr;
      w_we       = w_q4 && w_exec && W_wr;
      stt_we     = w_q4 && w_exec && STT_en;
      ir_load    = w_q4;
      pc_load    = w_q4 && w_exec && w_branch;
      pc_inc     = w_q4 && !pc_load;
      stack_push = w_q4 && w_exec && CALL;
      stack_pop  = w_q4 && w_exec && RETLW;
      wdt_clr    = w_q4 && w_exec && (CLRWDT || w_sleep_exec);

      phase     = r_phase;
      nop_cycle = r_nop;
      sleeping  = (r_state == ST_SLEEP);
      to_n      = r_to_n;
      pd_n      = r_pd_n;
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: expected output vectors are queued
// per clock as stimulus is applied and compared as each clock is observed.
module tb_instr_sequencer;

   localparam logic [3:0] Q0 = 4'b0000, Q1 = 4'b0001, Q2 = 4'b0010,
                          Q3 = 4'b0100, Q4 = 4'b1000;
   // strobe field order: rd fwe wwe swe irl pci pcl psh pop wdc
   localparam logic [9:0] S_RD  = 10'h200, S_FWE = 10'h100, S_WWE = 10'h080,
                          S_SWE = 10'h040, S_IRL = 10'h020, S_PCI = 10'h010,
                          S_PCL = 10'h008, S_PSH = 10'h004, S_POP = 10'h002,
                          S_WDC = 10'h001;
   // decode field order: GOTO CALL RETLW SLEEP CLRWDT FSZ BTFSS f_rd f_wr W_wr STT_en alu_zero
   localparam logic [11:0] D_GOTO = 12'h800, D_CALL = 12'h400, D_RET = 12'h200,
                           D_SLP  = 12'h100, D_CLR  = 12'h080, D_FSZ = 12'h040,
                           D_BTS  = 12'h020, D_FRD  = 12'h010, D_FWR = 12'h008,
                           D_WWR  = 12'h004, D_STT  = 12'h002, D_AZ  = 12'h001;

   logic clk = 1'b0;
   logic rst, stall, wake_req;
   logic GOTO, CALL, RETLW, SLEEP, CLRWDT, FSZ, BTFSS, f_rd, f_wr, W_wr, STT_en, alu_zero;
   logic [3:0] phase;
   logic f_rd_stb, f_we, w_we, stt_we, ir_load, pc_inc, pc_load;
   logic stack_push, stack_pop, wdt_clr, nop_cycle, sleeping, to_n, pd_n;

   int n_chk = 0;
   int n_pass = 0;
   logic [17:0] sb_q[$];
   logic [17:0] got, exp_v;

   always #5 clk = ~clk;

   instr_sequencer #(.STARTUP_CYCLES(4), .WAKE_SYNC(2)) dut (
      .clk(clk), .rst(rst), .stall(stall), .wake_req(wake_req),
      .GOTO(GOTO), .CALL(CALL), .RETLW(RETLW), .SLEEP(SLEEP), .CLRWDT(CLRWDT),
      .FSZ(FSZ), .BTFSS(BTFSS), .f_rd(f_rd), .f_wr(f_wr), .W_wr(W_wr),
      .STT_en(STT_en), .alu_zero(alu_zero),
      .phase(phase), .f_rd_stb(f_rd_stb), .f_we(f_we), .w_we(w_we), .stt_we(stt_we),
      .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
      .stack_push(stack_push), .stack_pop(stack_pop), .wdt_clr(wdt_clr),
      .nop_cycle(nop_cycle), .sleeping(sleeping), .to_n(to_n), .pd_n(pd_n)
   );

   function automatic logic [17:0] mk(input logic [3:0] ph, input logic [9:0] stb,
                                      input logic nop, input logic slp,
                                      input logic to_v, input logic pd_v);
      return {ph, stb, nop, slp, to_v, pd_v};
   endfunction

   function automatic logic [17:0] obs();
      return {phase, f_rd_stb, f_we, w_we, stt_we, ir_load, pc_inc, pc_load,
              stack_push, stack_pop, wdt_clr, nop_cycle, sleeping, to_n, pd_n};
   endfunction

   task automatic set_dec(input logic [11:0] d);
      {GOTO, CALL, RETLW, SLEEP, CLRWDT, FSZ, BTFSS, f_rd, f_wr, W_wr, STT_en, alu_zero} = d;
   endtask

   // Queue the four phase samples of one RUN instruction cycle.
   task automatic exp_cycle(input logic [9:0] q2, input logic [9:0] q4,
                            input logic nop, input logic pd_v);
      sb_q.push_back(mk(Q1, 10'h0, nop, 1'b0, 1'b1, pd_v));
      sb_q.push_back(mk(Q2, q2,    nop, 1'b0, 1'b1, pd_v));
      sb_q.push_back(mk(Q3, 10'h0, nop, 1'b0, 1'b1, pd_v));
      sb_q.push_back(mk(Q4, q4,    nop, 1'b0, 1'b1, pd_v));
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b1; wake_req = 1'b0; set_dec(12'h0);
      repeat (2) @(posedge clk);
      #1;
      sb_q.push_back(mk(Q0, 10'h0, 1'b1, 1'b0, 1'b1, 1'b1));
      got = obs(); exp_v = sb_q.pop_front(); n_chk++;
      if (got !== exp_v) $display("FAIL reset_state got=%h expected=%h", got, exp_v);
      else n_pass++;
      // Startup hold: stall is ignored in START, Q1 appears after the 4th clock.
      rst = 1'b0;
      for (int i = 0; i < 4; i++) sb_q.push_back(mk(Q0, 10'h0, 1'b1, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 4; i++) begin
         #1; got = obs(); exp_v = sb_q.pop_front(); n_chk++;
         if (got !== exp_v) $display("FAIL startup[%0d] got=%h expected=%h", i, got, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
      stall = 1'b0;
      set_dec(D_WWR | D_FRD | D_FWR);
      exp_cycle(10'h0, S_IRL | S_PCI, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #1; got = obs(); exp_v = sb_q.pop_front(); n_chk++;
         if (got !== exp_v) $display("FAIL first_cycle[%0d] got=%h expected=%h", i, got, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_addwf();
      set_dec(D_FRD | D_FWR | D_STT);
      exp_cycle(S_RD, S_FWE | S_SWE | S_IRL | S_PCI, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         #1; got = obs(); exp_v = sb_q.pop_front(); n_chk++;
         if (got !== exp_v) $display("FAIL addwf[%0d] got=%h expected=%h", i, got, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_call_ret();
      logic [11:0] dec [0:3];
      dec = '{D_CALL, D_CALL | D_FWR | D_WWR | D_FRD, D_RET, 12'h0};
      exp_cycle(10'h0, S_PSH | S_PCL | S_IRL, 1'b0, 1'b1);
      exp_cycle(10'h0, S_IRL | S_PCI,         1'b1, 1'b1);
      exp_cycle(10'h0, S_POP | S_PCL | S_IRL, 1'b0, 1'b1);
      exp_cycle(10'h0, S_IRL | S_PCI,         1'b1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         if (i % 4 == 0) set_dec(dec[i/4]);
         #1; got = obs(); exp_v = sb_q.pop_front(); n_chk++;
         if (got !== exp_v) $display("FAIL call_ret[%0d] got=%h expected=%h", i, got, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_skip();
      logic [11:0] dec [0:5];
      dec = '{D_FSZ | D_AZ | D_FWR, D_FSZ | D_AZ | D_FWR, D_FSZ | D_FWR,
              D_BTS, 12'h0, D_BTS | D_AZ};
      exp_cycle(10'h0, S_FWE | S_IRL | S_PCI, 1'b0, 1'b1);
      exp_cycle(10'h0, S_IRL | S_PCI,         1'b1, 1'b1);
      exp_cycle(10'h0, S_FWE | S_IRL | S_PCI, 1'b0, 1'b1);
      exp_cycle(10'h0, S_IRL | S_PCI,         1'b0, 1'b1);
      exp_cycle(10'h0, S_IRL | S_PCI,         1'b1, 1'b1);
      exp_cycle(10'h0, S_IRL | S_PCI,         1'b0, 1'b1);
      for (int i = 0; i < 24; i++) begin
         if (i % 4 == 0) set_dec(dec[i/4]);
         #1; got = obs(); exp_v = sb_q.pop_front(); n_chk++;
         if (got !== exp_v) $display("FAIL skip[%0d] got=%h expected=%h", i, got, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sleep();
      set_dec(D_SLP);
      exp_cycle(10'h0, S_WDC | S_IRL | S_PCI, 1'b0, 1'b1);
      // Three idle clocks, then wake: two sync stages plus the state register.
      for (int i = 0; i < 3 + 2 + 1; i++)
         sb_q.push_back(mk(Q0, 10'h0, 1'b0, 1'b1, 1'b1, 1'b0));
      exp_cycle(10'h0, S_WDC | S_IRL | S_PCI, 1'b0, 1'b0);
      exp_cycle(10'h0, S_IRL | S_PCI,         1'b0, 1'b1);
      for (int i = 0; i < 18; i++) begin
         if (i == 4) set_dec(12'h0);
         if (i == 7) wake_req = 1'b1;
         if (i == 10) begin wake_req = 1'b0; set_dec(D_CLR); end
         if (i == 14) set_dec(12'h0);
         #1; got = obs(); exp_v = sb_q.pop_front(); n_chk++;
         if (got !== exp_v) $display("FAIL sleep_wake[%0d] got=%h expected=%h", i, got, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_stall();
      logic st [0:9];
      st = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      set_dec(D_FRD | D_FWR);
      sb_q.push_back(mk(Q1, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1));
      sb_q.push_back(mk(Q2, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1));
      sb_q.push_back(mk(Q2, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1));
      sb_q.push_back(mk(Q2, S_RD,  1'b0, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 4; i++) sb_q.push_back(mk(Q3, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1));
      sb_q.push_back(mk(Q4, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1));
      sb_q.push_back(mk(Q4, S_FWE | S_IRL | S_PCI, 1'b0, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 10; i++) begin
         stall = st[i];
         #1; got = obs(); exp_v = sb_q.pop_front(); n_chk++;
         if (got !== exp_v) $display("FAIL stall[%0d] got=%h expected=%h", i, got, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
      stall = 1'b0;
   endtask

   task automatic test_reset_mid();
      set_dec(D_WWR);
      sb_q.push_back(mk(Q1, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1));
      sb_q.push_back(mk(Q2, 10'h0, 1'b0, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 6; i++) sb_q.push_back(mk(Q0, 10'h0, 1'b1, 1'b0, 1'b1, 1'b1));
      sb_q.push_back(mk(Q1, 10'h0, 1'b1, 1'b0, 1'b1, 1'b1));
      for (int i = 0; i < 9; i++) begin
         if (i == 2) rst = 1'b1;
         if (i == 4) rst = 1'b0;
         #1; got = obs(); exp_v = sb_q.pop_front(); n_chk++;
         if (got !== exp_v) $display("FAIL reset_mid[%0d] got=%h expected=%h", i, got, exp_v);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout checks=%0d passed=%0d", n_chk, n_pass);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_addwf();
      test_call_ret();
      test_skip();
      test_sleep();
      test_stall();
      test_reset_mid();
      if (sb_q.size() != 0) $display("scoreboard residue %0d", sb_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
